regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the CPU datapath, replacing the fixed three-read, one-write register files. It adds a configurable number of packed read ports, a second write port (ALU and load return), optional write-to-read bypass, a hard-wired zero register option and a per-register pending scoreboard. After reset it runs a sequential clear of the storage array and holds `ready` low until the clear completes.

## Interface

**Parameters**

- `WIDTH`, 32, data width.
- `RSELWIDTH`, 4, register select width; depth is `2**RSELWIDTH`.
- `NREAD`, 3, number of read ports, 1..8.
- `BYPASS`, 1, when 1 a read of a register being written this cycle returns the incoming write data.
- `ZERO_REG`, 0, when 1 register 0 always reads 0, ignores writes and is never marked pending.

**Ports**

- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `ready` output 1: high when the clear sequence is done and the file accepts writes.
- `we0` input 1: write enable, port 0 (ALU).
- `wsel0` input RSELWIDTH: register selected by port 0.
- `wdata0` input WIDTH: write data, port 0.
- `we1` input 1: write enable, port 1 (load).
- `wsel1` input RSELWIDTH: register selected by port 1.
- `wdata1` input WIDTH: write data, port 1.
- `mark` input 1: set the pending bit of `mark_sel`.
- `mark_sel` input RSELWIDTH: register to mark pending.
- `rsel` input NREAD*RSELWIDTH: packed read selects; port i uses bits `[i*RSELWIDTH +: RSELWIDTH]`.
- `rdata` output NREAD*WIDTH: packed read data; port i uses bits `[i*WIDTH +: WIDTH]`.
- `rpend` output NREAD: pending bit of each read port's selected register.

## Operation

**States and transitions**

- The block has two states, CLEAR and RUN.
- `rst` = 1 at a clock edge: next state is CLEAR, clear counter := 0, all pending bits := 0.
- `rst` has priority over every other input.

**CLEAR**

- Each cycle, `R[counter]` := 0 and the counter increments.
- On the cycle the counter reaches `2**RSELWIDTH-1`: that entry is written, then the next state is RUN.
- The clear takes exactly `2**RSELWIDTH` cycles.
- `ready` = 0.
- `we0`, `we1` and `mark` are ignored.
- All `rdata` = 0 and all `rpend` = 0.

**RUN**

- `ready` = 1.
- Writes: `we0` writes `R[wsel0]` := `wdata0`; `we1` writes `R[wsel1]` := `wdata1`.
- Same-register write: if both ports write the same register in one cycle, port 1 wins.
- Pending clear: any write to register r clears `pend[r]`.
- Pending set: `mark` sets `pend[mark_sel]`. If the same register is marked and written in one cycle, the mark wins and `pend` = 1; the new producer has been issued.
- Reads are combinational: `rdata[i] = R[rsel_i]` and `rpend[i] = pend[rsel_i]`.
- With `BYPASS` = 1, a read of a register that is written this cycle returns that cycle's winning write data, with port 1 priority. `rpend` is not bypassed and shows the registered value.
- With `ZERO_REG` = 1, register 0 reads 0, `rpend` for register 0 = 0, and writes and marks to register 0 are dropped.

**Reset values**

- `ready` = 0.
- `rdata` = 0.
- `rpend` = 0.
- The storage array is undefined until the clear completes, but it is never visible because reads return 0 during CLEAR.

**Reset mid-operation**

- `rst` asserted during CLEAR restarts the counter at 0.
- `rst` asserted during RUN discards any same-cycle write or mark.

## Timing

- Read latency is 0 cycles (combinational from `rsel`).
- Write to read-visibility: next cycle when `BYPASS` = 0; same cycle when `BYPASS` = 1.
- Mark to `rpend` = 1: next cycle. Write to `rpend` = 0: next cycle.
- `ready` rises on the edge that ends the last clear cycle: `2**RSELWIDTH` cycles after the reset edge is released, with 16 cycles at the defaults.
- All state changes happen only on the rising edge of `clk`.
- There is no backpressure and no handshake beyond `ready`. Upstream must not issue writes or marks while `ready` = 0; any that arrive are lost.

## Test plan

- **Reset and clear:** assert `rst` for 1 cycle with the defaults, preloaded with garbage.
  - `ready` must be 0 for exactly 16 cycles, then go to 1.
  - Every register must read 0 afterwards, and `rpend` must be 0.
- **Dual-write collision:** in RUN, set `we0` with `wsel0` = 5, `wdata0` = 0x11111111, and `we1` with `wsel1` = 5, `wdata1` = 0x22222222.
  - Next cycle, `R[5]` must read 0x22222222.
  - With `BYPASS` = 1, a port reading register 5 in the same cycle must show 0x22222222.
- **Bypass on and off:** write 0xDEADBEEF to register 3 while read port 2 selects register 3.
  - `BYPASS` = 1: `rdata[2]` = 0xDEADBEEF in the same cycle.
  - `BYPASS` = 0: `rdata[2]` shows the old value, then 0xDEADBEEF the next cycle.
- **Scoreboard:** `mark` register 7.
  - Next cycle, `rpend` = 1 for any port selecting register 7.
  - Write register 7: `rpend` = 0 the next cycle.
  - Mark and write register 7 in the same cycle: `rpend` stays 1.
- **Zero register:** with `ZERO_REG` = 1, write 0xFFFFFFFF to register 0 and mark register 0.
  - Register 0 must read 0 and `rpend` must be 0.
  - A write to register 1 must be unaffected.
- **Reset mid-clear and mid-write:** assert `rst` at clear cycle 9, then again during a RUN write to register 4 of 0x1234.
  - Each reset gives a full 16-cycle clear.
  - Register 4 must read 0 afterwards.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bus bundle for the multi-port register file.
//   master : datapath side; drives write ports, mark request and read selects,
//            receives ready, read data and read pending bits.
//   slave  : register file side.
//   Signals:
//     ready            file has finished its clear and accepts writes
//     we0/wsel0/wdata0 write port 0 (ALU)
//     we1/wsel1/wdata1 write port 1 (load return), wins on same-register writes
//     mark/mark_sel    set the pending bit of a register
//     rsel             packed read selects, port i at [i*RSELWIDTH +: RSELWIDTH]
//     rdata            packed read data,    port i at [i*WIDTH +: WIDTH]
//     rpend            pending bit of each read port's selected register
interface regfile_mp_if #(
    parameter int WIDTH     = 32,
    parameter int RSELWIDTH = 4,
    parameter int NREAD     = 3
);
    logic                       ready;
    logic                       we0;
    logic [RSELWIDTH-1:0]       wsel0;
    logic [WIDTH-1:0]           wdata0;
    logic                       we1;
    logic [RSELWIDTH-1:0]       wsel1;
    logic [WIDTH-1:0]           wdata1;
    logic                       mark;
    logic [RSELWIDTH-1:0]       mark_sel;
    logic [NREAD*RSELWIDTH-1:0] rsel;
    logic [NREAD*WIDTH-1:0]     rdata;
    logic [NREAD-1:0]           rpend;

    modport master (
        input  ready, rdata, rpend,
        output we0, wsel0, wdata0, we1, wsel1, wdata1, mark, mark_sel, rsel
    );

    modport slave (
        output ready, rdata, rpend,
        input  we0, wsel0, wdata0, we1, wsel1, wdata1, mark, mark_sel, rsel
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port register file with two write ports, NREAD
//   combinational read ports, optional write-to-read bypass, optional
//   hard-wired zero register and a per-register pending scoreboard.
//   After reset the storage array is cleared one entry per cycle; ready stays
//   low and all reads return zero until the clear has finished.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  regfile_mp_if slave modport (write ports, mark, reads, ready)
module regfile_mp #(
    parameter int WIDTH     = 32,
    parameter int RSELWIDTH = 4,
    parameter int NREAD     = 3,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**RSELWIDTH;
    localparam logic [RSELWIDTH-1:0] LAST_IDX = RSELWIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state_q;
    logic [RSELWIDTH-1:0]   clearCnt_q;
    logic                   ready_q;
    logic [DEPTH-1:0]       pend_q;
    logic [DEPTH-1:0]       pend_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic run;
    logic wrEn0;
    logic wrEn1;
    logic markEn;

    assign run = (state_q == RUN);

    // Effective write/mark strobes: only in RUN, never on a reset edge, and
    // register 0 is untouchable when it is hard-wired to zero.
    assign wrEn0  = bus.we0 && run && !rst &&
                    !((ZERO_REG == 1) && (bus.wsel0 == '0));
    assign wrEn1  = bus.we1 && run && !rst &&
                    !((ZERO_REG == 1) && (bus.wsel1 == '0));
    assign markEn = bus.mark && run && !rst &&
                    !((ZERO_REG == 1) && (bus.mark_sel == '0));

    // Writes clear the pending bit first; a mark applied afterwards wins
    // because the register has a newly issued producer.
    always_comb begin
        pend_d = pend_q;
        if (wrEn0) begin
            pend_d[bus.wsel0] = 1'b0;
        end
        if (wrEn1) begin
            pend_d[bus.wsel1] = 1'b0;
        end
        if (markEn) begin
            pend_d[bus.mark_sel] = 1'b1;
        end
    end

    // Control FSM: reset restarts the clear sequence from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clearCnt_q <= '0;
            ready_q    <= 1'b0;
            pend_q     <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clearCnt_q <= clearCnt_q + RSELWIDTH'(1);
                    if (clearCnt_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    pend_q <= pend_d;
                end
                default: begin
                    state_q <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: no reset value; it is zeroed by the clear sequence.
    // Port 1 is written last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clearCnt_q] <= '0;
            end else begin
                if (wrEn0) begin
                    mem_q[bus.wsel0] <= bus.wdata0;
                end
                if (wrEn1) begin
                    mem_q[bus.wsel1] <= bus.wdata1;
                end
            end
        end
    end

    assign bus.ready = ready_q;

    // Combinational read ports. Bypass forwards the winning write data of
    // this cycle; the pending bit is always the registered value.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [RSELWIDTH-1:0] sel;
        logic [WIDTH-1:0]     data;
        logic                 pendBit;

        assign sel = bus.rsel[i*RSELWIDTH +: RSELWIDTH];

        always_comb begin
            data    = mem_q[sel];
            pendBit = pend_q[sel];
            if (BYPASS == 1) begin
                if (wrEn0 && (bus.wsel0 == sel)) begin
                    data = bus.wdata0;
                end
                if (wrEn1 && (bus.wsel1 == sel)) begin
                    data = bus.wdata1;
                end
            end
            if ((ZERO_REG == 1) && (sel == '0)) begin
                data    = '0;
                pendBit = 1'b0;
            end
            if (!run) begin
                data    = '0;
                pendBit = 1'b0;
            end
        end

        assign bus.rdata[i*WIDTH +: WIDTH] = data;
        assign bus.rpend[i]                = pendBit;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Self-checking bench for regfile_mp. Three instances share one stimulus:
//     dut 0: BYPASS=1, ZERO_REG=0 (defaults)
//     dut 1: BYPASS=0
//     dut 2: ZERO_REG=1
//   Expected read results are queued as stimulus is applied and compared
//   mid-cycle when the combinational outputs have settled.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3)) ifA ();
    regfile_mp_if #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3)) ifB ();
    regfile_mp_if #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3)) ifZ ();

    regfile_mp #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3), .BYPASS(1), .ZERO_REG(0))
        dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    regfile_mp #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3), .BYPASS(0), .ZERO_REG(0))
        dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
    regfile_mp #(.WIDTH(32), .RSELWIDTH(4), .NREAD(3), .BYPASS(1), .ZERO_REG(1))
        dutZ (.clk(clk), .rst(rst), .bus(ifZ.slave));

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        bit          isPend;
        logic [31:0] value;
    } expEntry_t;

    expEntry_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observe(input int dut, input int port, input bit isPend);
        logic [95:0] d;
        logic [2:0]  p;
        case (dut)
            0:       begin d = ifA.rdata; p = ifA.rpend; end
            1:       begin d = ifB.rdata; p = ifB.rpend; end
            default: begin d = ifZ.rdata; p = ifZ.rpend; end
        endcase
        if (isPend) begin
            return {31'b0, p[port]};
        end
        return d[port*32 +: 32];
    endfunction

    task automatic pushExpect(input string tag, input int dut, input int port,
                              input bit isPend, input logic [31:0] value);
        expEntry_t e;
        e.tag    = $sformatf("%s[d%0d p%0d %s]", tag, dut, port, isPend ? "pend" : "data");
        e.dut    = dut;
        e.port   = port;
        e.isPend = isPend;
        e.value  = value;
        expQ.push_back(e);
    endtask

    task automatic checkScoreboard();
        expEntry_t e;
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, observe(e.dut, e.port, e.isPend), e.value);
        end
    endtask

    task automatic applyStimulus(input logic we0, input logic [3:0] wsel0, input logic [31:0] wdata0,
                                 input logic we1, input logic [3:0] wsel1, input logic [31:0] wdata1,
                                 input logic mark, input logic [3:0] markSel);
        ifA.we0 = we0; ifA.wsel0 = wsel0; ifA.wdata0 = wdata0;
        ifA.we1 = we1; ifA.wsel1 = wsel1; ifA.wdata1 = wdata1;
        ifA.mark = mark; ifA.mark_sel = markSel;
        ifB.we0 = we0; ifB.wsel0 = wsel0; ifB.wdata0 = wdata0;
        ifB.we1 = we1; ifB.wsel1 = wsel1; ifB.wdata1 = wdata1;
        ifB.mark = mark; ifB.mark_sel = markSel;
        ifZ.we0 = we0; ifZ.wsel0 = wsel0; ifZ.wdata0 = wdata0;
        ifZ.we1 = we1; ifZ.wsel1 = wsel1; ifZ.wdata1 = wdata1;
        ifZ.mark = mark; ifZ.mark_sel = markSel;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    endtask

    task automatic setRsel(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
        ifA.rsel = {p2, p1, p0};
        ifB.rsel = {p2, p1, p0};
        ifZ.rsel = {p2, p1, p0};
    endtask

    // Compare queued expectations mid-cycle, then advance past the next edge.
    task automatic step();
        @(negedge clk);
        checkScoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts mid-cycle samples with ready low; reads must be zero while clearing.
    task automatic waitReady(input string tag);
        int n = 0;
        pushExpect({tag, "_clrRead"}, 0, 0, 1'b0, 32'h0);
        pushExpect({tag, "_clrRead"}, 1, 0, 1'b0, 32'h0);
        @(negedge clk);
        checkScoreboard();
        while (ifA.ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_clearLen"}, 32'(n), 32'd16);
        checkOutput({tag, "_readyB"}, {31'b0, ifB.ready}, 32'd1);
        checkOutput({tag, "_readyZ"}, {31'b0, ifZ.ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        setRsel(4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        waitReady("init");

        // Fill every register with garbage, then make sure it is visible.
        for (int r = 0; r < 16; r++) begin
            applyStimulus(1'b1, 4'(r), 32'hA5A50000 | 32'(r), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
            @(posedge clk);
            #1;
        end
        idle();
        setRsel(4'd9, 4'd9, 4'd9);
        pushExpect("garbage", 0, 0, 1'b0, 32'hA5A50009);
        step();

        // One-cycle reset must give a full clear.
        doReset();
        waitReady("rstClear");
        for (int r = 0; r < 16; r++) begin
            setRsel(4'(r), 4'(r), 4'(r));
            for (int p = 0; p < 3; p++) begin
                pushExpect($sformatf("cleared%0d", r), 0, p, 1'b0, 32'h0);
                pushExpect($sformatf("clrPend%0d", r), 0, p, 1'b1, 32'h0);
            end
            step();
        end

        // Dual-write collision on register 5: port 1 wins.
        setRsel(4'd5, 4'd0, 4'd0);
        applyStimulus(1'b1, 4'd5, 32'h11111111, 1'b1, 4'd5, 32'h22222222, 1'b0, 4'd0);
        pushExpect("collBypass", 0, 0, 1'b0, 32'h22222222);
        pushExpect("collNoBypass", 1, 0, 1'b0, 32'h00000000);
        pushExpect("collBypassZ", 2, 0, 1'b0, 32'h22222222);
        step();
        idle();
        pushExpect("collNext", 0, 0, 1'b0, 32'h22222222);
        pushExpect("collNext", 1, 0, 1'b0, 32'h22222222);
        step();

        // Bypass on/off: register 3 read on port 2 while being written.
        setRsel(4'd0, 4'd0, 4'd3);
        applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        pushExpect("bypSame", 0, 2, 1'b0, 32'hDEADBEEF);
        pushExpect("noBypSame", 1, 2, 1'b0, 32'h00000000);
        step();
        idle();
        pushExpect("bypNext", 0, 2, 1'b0, 32'hDEADBEEF);
        pushExpect("noBypNext", 1, 2, 1'b0, 32'hDEADBEEF);
        step();

        // Pending scoreboard on register 7.
        setRsel(4'd7, 4'd7, 4'd7);
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
        pushExpect("markSame", 0, 0, 1'b1, 32'd0);
        step();
        idle();
        for (int p = 0; p < 3; p++) begin
            pushExpect("markNext", 0, p, 1'b1, 32'd1);
        end
        pushExpect("markNext", 1, 0, 1'b1, 32'd1);
        pushExpect("markNext", 2, 0, 1'b1, 32'd1);
        step();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0);
        pushExpect("wrPendSame", 0, 1, 1'b1, 32'd1);
        step();
        idle();
        for (int p = 0; p < 3; p++) begin
            pushExpect("wrPendClr", 0, p, 1'b1, 32'd0);
        end
        pushExpect("wrPendData", 0, 0, 1'b0, 32'h00000077);
        step();
        applyStimulus(1'b1, 4'd7, 32'h00000078, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
        step();
        idle();
        pushExpect("markWinsPend", 0, 0, 1'b1, 32'd1);
        pushExpect("markWinsPend", 1, 0, 1'b1, 32'd1);
        pushExpect("markWinsData", 0, 0, 1'b0, 32'h00000078);
        step();

        // Zero register: write and mark register 0, write register 1.
        setRsel(4'd0, 4'd1, 4'd0);
        applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd1, 32'h00000001, 1'b1, 4'd0);
        pushExpect("zeroSame", 2, 0, 1'b0, 32'h00000000);
        pushExpect("zeroSameR1", 2, 1, 1'b0, 32'h00000001);
        pushExpect("nonZeroSame", 0, 0, 1'b0, 32'hFFFFFFFF);
        step();
        idle();
        pushExpect("zeroRead", 2, 0, 1'b0, 32'h00000000);
        pushExpect("zeroPend", 2, 0, 1'b1, 32'd0);
        pushExpect("zeroR1", 2, 1, 1'b0, 32'h00000001);
        pushExpect("nonZeroRead", 0, 0, 1'b0, 32'hFFFFFFFF);
        pushExpect("nonZeroPend", 0, 0, 1'b1, 32'd1);
        pushExpect("nonZeroNoByp", 1, 0, 1'b0, 32'hFFFFFFFF);
        step();

        // Reset at clear cycle 9 restarts the full clear.
        doReset();
        repeat (9) @(posedge clk);
        #1;
        checkOutput("midClearReady", {31'b0, ifA.ready}, 32'd0);
        doReset();
        waitReady("midClear");

        // Reset during a RUN write to register 4.
        setRsel(4'd4, 4'd4, 4'd4);
        applyStimulus(1'b1, 4'd4, 32'h00001234, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        waitReady("midWrite");
        pushExpect("reg4Cleared", 0, 0, 1'b0, 32'h0);
        pushExpect("reg4Cleared", 1, 0, 1'b0, 32'h0);
        pushExpect("reg4Cleared", 2, 0, 1'b0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
